ssm_tile_streamer: RTL and testbench

SSM_TILE_STREAMER -- requirements
Module: ssm_tile_streamer

---
 rtl/ssm_tile_streamer_if.sv | 51 +++++
 rtl/ssm_tile_streamer.sv | 151 +++++++++++++++
 tb/tb_ssm_tile_streamer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssm_tile_streamer_if.sv
// Group-in / tile-out handshake bundle for ssm_tile_streamer.
// The slave modport is the streamer's view; the master modport is the surrounding environment's view.
interface ssm_tile_streamer_if #(
    parameter int DW        = 16,
    parameter int N_TILE    = 4,
    parameter int N_TOTAL   = 128,
    parameter int MAX_OUTST = 4
);
    localparam int TILES = N_TOTAL / N_TILE;
    localparam int IW    = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int OW    = $clog2(MAX_OUTST + 1);

    logic                    grp_valid_i;
    logic                    grp_ready_o;
    logic [DW-1:0]           dt_i;
    logic [DW-1:0]           dA_i;
    logic [DW-1:0]           x_i;
    logic [DW-1:0]           D_i;
    logic [N_TOTAL*DW-1:0]   B_vec_i;
    logic [N_TOTAL*DW-1:0]   C_vec_i;
    logic [N_TOTAL*DW-1:0]   hprev_vec_i;
    logic                    tile_valid_o;
    logic                    tile_ready_i;
    logic [DW-1:0]           dt_o;
    logic [DW-1:0]           dA_o;
    logic [DW-1:0]           x_o;
    logic [DW-1:0]           D_o;
    logic [N_TILE*DW-1:0]    B_tile_o;
    logic [N_TILE*DW-1:0]    C_tile_o;
    logic [N_TILE*DW-1:0]    hprev_tile_o;
    logic [IW-1:0]           tile_idx_o;
    logic                    tile_last_o;
    logic                    y_final_valid_i;
    logic [OW-1:0]           outst_o;
    logic                    busy_o;
    logic                    underflow_o;

    modport slave (
        input  grp_valid_i, dt_i, dA_i, x_i, D_i, B_vec_i, C_vec_i, hprev_vec_i,
               tile_ready_i, y_final_valid_i,
        output grp_ready_o, tile_valid_o, dt_o, dA_o, x_o, D_o, B_tile_o, C_tile_o,
               hprev_tile_o, tile_idx_o, tile_last_o, outst_o, busy_o, underflow_o
    );

    modport master (
        output grp_valid_i, dt_i, dA_i, x_i, D_i, B_vec_i, C_vec_i, hprev_vec_i,
               tile_ready_i, y_final_valid_i,
        input  grp_ready_o, tile_valid_o, dt_o, dA_o, x_o, D_o, B_tile_o, C_tile_o,
               hprev_tile_o, tile_idx_o, tile_last_o, outst_o, busy_o, underflow_o
    );
endinterface

// File: rtl/ssm_tile_streamer.sv
// Latches one SSM group (scalars + full B/C/hprev vectors) and streams it out as N_TILE-lane tiles.
// Optional macro SSM_STREAMER_CREDIT_EN gates group acceptance on the count of groups awaiting y_final.
module ssm_tile_streamer #(
    parameter int DW        = 16,
    parameter int N_TILE    = 4,
    parameter int N_TOTAL   = 128,
    parameter int MAX_OUTST = 4
) (
    input logic              clk,
    input logic              rstn,
    ssm_tile_streamer_if.slave bus
);
    localparam int TILES = N_TOTAL / N_TILE;
    localparam int IW    = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int OW    = $clog2(MAX_OUTST + 1);
    localparam int TW    = N_TILE * DW;
    localparam int VW    = N_TOTAL * DW;
    localparam logic [IW-1:0] LAST_IDX  = IW'(TILES - 1);
    localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            armed_q;
    logic [OW-1:0]   outst_q;
    logic            underflow_q;
    logic [DW-1:0]   dt_q, da_q, x_q, d_q;
    logic [VW-1:0]   b_vec_q, c_vec_q, h_vec_q;
    logic [TW-1:0]   b_tile_q, c_tile_q, h_tile_q;
    logic            credit_ok, grp_ready, tile_valid, is_last, accept, beat;
    logic [TW-1:0]   b_slices [TILES];
    logic [TW-1:0]   c_slices [TILES];
    logic [TW-1:0]   h_slices [TILES];

    for (genvar t = 0; t < TILES; t++) begin : g_slice
        assign b_slices[t] = b_vec_q[t*TW +: TW];
        assign c_slices[t] = c_vec_q[t*TW +: TW];
        assign h_slices[t] = h_vec_q[t*TW +: TW];
    end

`ifdef SSM_STREAMER_CREDIT_EN
    assign credit_ok = (outst_q < OUTST_MAX) || bus.y_final_valid_i;
`else
    assign credit_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        grp_ready  = 1'b0;
        tile_valid = 1'b0;
        is_last    = 1'b0;
        case (state_q)
            IDLE: begin
                // armed_q keeps ready low until the first edge after reset release
                grp_ready = armed_q && credit_ok;
                if (bus.grp_valid_i && grp_ready) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                tile_valid = 1'b1;
                is_last    = (idx_q == LAST_IDX);
                if (bus.tile_ready_i) begin
                    if (is_last) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = grp_ready && bus.grp_valid_i;
    assign beat   = tile_valid && bus.tile_ready_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            armed_q <= 1'b1;
        end
    end

    // Tile outputs are registered so they hold the final slice while idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dt_q     <= '0;
            da_q     <= '0;
            x_q      <= '0;
            d_q      <= '0;
            b_vec_q  <= '0;
            c_vec_q  <= '0;
            h_vec_q  <= '0;
            b_tile_q <= '0;
            c_tile_q <= '0;
            h_tile_q <= '0;
        end else if (accept) begin
            dt_q     <= bus.dt_i;
            da_q     <= bus.dA_i;
            x_q      <= bus.x_i;
            d_q      <= bus.D_i;
            b_vec_q  <= bus.B_vec_i;
            c_vec_q  <= bus.C_vec_i;
            h_vec_q  <= bus.hprev_vec_i;
            b_tile_q <= bus.B_vec_i[TW-1:0];
            c_tile_q <= bus.C_vec_i[TW-1:0];
            h_tile_q <= bus.hprev_vec_i[TW-1:0];
        end else if (beat && !is_last) begin
            b_tile_q <= b_slices[idx_d];
            c_tile_q <= c_slices[idx_d];
            h_tile_q <= h_slices[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outst_q     <= '0;
            underflow_q <= 1'b0;
        end else if (accept && !bus.y_final_valid_i) begin
            if (outst_q != OUTST_MAX) outst_q <= outst_q + 1'b1;
        end else if (!accept && bus.y_final_valid_i) begin
            if (outst_q == '0) underflow_q <= 1'b1;
            else               outst_q     <= outst_q - 1'b1;
        end
    end

    assign bus.grp_ready_o  = grp_ready;
    assign bus.tile_valid_o = tile_valid;
    assign bus.tile_last_o  = is_last;
    assign bus.tile_idx_o   = idx_q;
    assign bus.dt_o         = dt_q;
    assign bus.dA_o         = da_q;
    assign bus.x_o          = x_q;
    assign bus.D_o          = d_q;
    assign bus.B_tile_o     = b_tile_q;
    assign bus.C_tile_o     = c_tile_q;
    assign bus.hprev_tile_o = h_tile_q;
    assign bus.outst_o      = outst_q;
    assign bus.busy_o       = (state_q != IDLE) || (outst_q != '0);
    assign bus.underflow_o  = underflow_q;
endmodule

// File: tb/tb_ssm_tile_streamer.sv
// Self-checking bench for ssm_tile_streamer: a group-level model checked every cycle plus directed literal checks.
// Builds with or without SSM_STREAMER_CREDIT_EN; the credit section adapts to the macro.
module tb_ssm_tile_streamer;
    localparam int DW        = 16;
    localparam int N_TILE    = 4;
    localparam int N_TOTAL   = 128;
    localparam int MAX_OUTST = 4;
    localparam int TILES     = N_TOTAL / N_TILE;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ssm_tile_streamer_if #(.DW(DW), .N_TILE(N_TILE), .N_TOTAL(N_TOTAL), .MAX_OUTST(MAX_OUTST)) bus ();

    ssm_tile_streamer #(.DW(DW), .N_TILE(N_TILE), .N_TOTAL(N_TOTAL), .MAX_OUTST(MAX_OUTST)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    logic [DW-1:0] lane_b [N_TOTAL];
    logic [DW-1:0] lane_c [N_TOTAL];
    logic [DW-1:0] lane_h [N_TOTAL];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Group-level model: which group is held, which beat is due, what has been shown.
    logic          m_stream, m_armed, m_under, m_credit_ok, m_accept;
    int            m_k, m_show, m_outst;
    logic [DW-1:0] m_b [N_TOTAL];
    logic [DW-1:0] m_c [N_TOTAL];
    logic [DW-1:0] m_h [N_TOTAL];
    logic [DW-1:0] m_dt, m_da, m_x, m_d;

`ifdef SSM_STREAMER_CREDIT_EN
    assign m_credit_ok = (m_outst < MAX_OUTST) || bus.y_final_valid_i;
`else
    assign m_credit_ok = 1'b1;
`endif
    assign m_accept = m_armed && !m_stream && m_credit_ok && bus.grp_valid_i;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_stream <= 1'b0; m_armed <= 1'b0; m_under <= 1'b0;
            m_k <= 0; m_show <= 0; m_outst <= 0;
            m_dt <= '0; m_da <= '0; m_x <= '0; m_d <= '0;
            for (int n = 0; n < N_TOTAL; n++) begin
                m_b[n] <= '0; m_c[n] <= '0; m_h[n] <= '0;
            end
        end else begin
            m_armed <= 1'b1;
            if (m_accept) begin
                m_stream <= 1'b1; m_k <= 0; m_show <= 0;
                m_dt <= bus.dt_i; m_da <= bus.dA_i; m_x <= bus.x_i; m_d <= bus.D_i;
                for (int n = 0; n < N_TOTAL; n++) begin
                    m_b[n] <= lane_b[n]; m_c[n] <= lane_c[n]; m_h[n] <= lane_h[n];
                end
            end else if (m_stream && bus.tile_ready_i) begin
                if (m_k == TILES - 1) begin
                    m_stream <= 1'b0; m_k <= 0;
                end else begin
                    m_k <= m_k + 1; m_show <= m_k + 1;
                end
            end
            if (m_accept && !bus.y_final_valid_i) begin
                if (m_outst < MAX_OUTST) m_outst <= m_outst + 1;
            end else if (!m_accept && bus.y_final_valid_i) begin
                if (m_outst == 0) m_under <= 1'b1;
                else              m_outst <= m_outst - 1;
            end
        end
    end

    int            beats = 0, lasts = 0, valid_cycles = 0, first_idx = -1;
    logic [63:0]   b_at5 = '0;
    logic [63:0]   eb, ec, eh;

    // Compare process plus beat monitor, on the falling edge.
    always @(negedge clk) begin
        for (int j = 0; j < N_TILE; j++) begin
            eb[j*DW +: DW] = m_b[m_show*N_TILE + j];
            ec[j*DW +: DW] = m_c[m_show*N_TILE + j];
            eh[j*DW +: DW] = m_h[m_show*N_TILE + j];
        end
        checkOutput("tile_valid", 64'(bus.tile_valid_o), 64'(m_stream));
        checkOutput("tile_idx",   64'(bus.tile_idx_o),   64'(m_k));
        checkOutput("tile_last",  64'(bus.tile_last_o),  64'(m_stream && (m_k == TILES - 1)));
        checkOutput("B_tile",     64'(bus.B_tile_o),     eb);
        checkOutput("C_tile",     64'(bus.C_tile_o),     ec);
        checkOutput("hprev_tile", 64'(bus.hprev_tile_o), eh);
        checkOutput("dt",         64'(bus.dt_o),         64'(m_dt));
        checkOutput("dA",         64'(bus.dA_o),         64'(m_da));
        checkOutput("x",          64'(bus.x_o),          64'(m_x));
        checkOutput("D",          64'(bus.D_o),          64'(m_d));
        checkOutput("outst",      64'(bus.outst_o),      64'(m_outst));
        checkOutput("busy",       64'(bus.busy_o),       64'(m_stream || (m_outst != 0)));
        checkOutput("underflow",  64'(bus.underflow_o),  64'(m_under));
        checkOutput("grp_ready",  64'(bus.grp_ready_o),  64'(m_armed && !m_stream && m_credit_ok));
        if (bus.tile_valid_o) valid_cycles++;
        if (bus.tile_valid_o && bus.tile_ready_i) begin
            if (beats == 0) first_idx = int'(bus.tile_idx_o);
            if (bus.tile_idx_o == 5) b_at5 = 64'(bus.B_tile_o);
            if (bus.tile_last_o) lasts++;
            beats++;
        end
    end

    task automatic build_group(input int g);
        for (int n = 0; n < N_TOTAL; n++) begin
            if (g == 0) begin
                lane_b[n] = 16'(n);
                lane_c[n] = 16'h3C00;
                lane_h[n] = 16'h0000;
            end else begin
                lane_b[n] = 16'(g * 32'h200 + n);
                lane_c[n] = 16'(32'h3C00 + g * 5 + n * 3);
                lane_h[n] = 16'(32'h8000 + g * 32'h100 + n);
            end
            bus.B_vec_i[n*DW +: DW]     = lane_b[n];
            bus.C_vec_i[n*DW +: DW]     = lane_c[n];
            bus.hprev_vec_i[n*DW +: DW] = lane_h[n];
        end
        bus.dt_i = 16'(g + 1);
        bus.dA_i = 16'(g + 16'h40);
        bus.x_i  = 16'(g * 3 + 16'h100);
        bus.D_i  = 16'(16'hA000 + g);
        beats = 0; lasts = 0; valid_cycles = 0; first_idx = -1;
    endtask

    // Offer group g and return one edge after it is accepted (bounded).
    task automatic applyStimulus(input int g);
        int  n   = 0;
        bit  got = 1'b0;
        build_group(g);
        bus.grp_valid_i = 1'b1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (bus.grp_ready_o) got = 1'b1;
            else n++;
        end
        if (got) begin
            @(posedge clk); #1;
        end else begin
            checkOutput("accept_timeout", 64'(0), 64'(1));
        end
        bus.grp_valid_i = 1'b0;
    endtask

    task automatic wait_group_done();
        int n = 0;
        while (beats < TILES && n < 300) begin
            @(posedge clk); n++;
        end
        #1;
        if (n >= 300) checkOutput("group_done_timeout", 64'(beats), 64'(TILES));
    endtask

    task automatic pulse_yfinal();
        bus.y_final_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.y_final_valid_i = 1'b0;
    endtask

    initial begin
        bus.grp_valid_i     = 1'b0;
        bus.tile_ready_i    = 1'b1;
        bus.y_final_valid_i = 1'b0;
        build_group(0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_grp_ready",  64'(bus.grp_ready_o),  64'(0));
        checkOutput("rst_tile_valid", 64'(bus.tile_valid_o), 64'(0));
        checkOutput("rst_outst",      64'(bus.outst_o),      64'(0));
        rstn = 1'b1;
        @(posedge clk); #1;

        // Basic group: B lane n = n, C = 0x3C00, hprev = 0
        applyStimulus(0);
        wait_group_done();
        checkOutput("basic_beats",     64'(beats),            64'(32));
        checkOutput("basic_lasts",     64'(lasts),            64'(1));
        checkOutput("basic_first_idx", 64'(first_idx),        64'(0));
        checkOutput("basic_b_beat5",   b_at5,                 64'h0017_0016_0015_0014);
        checkOutput("basic_outst",     64'(bus.outst_o),      64'(1));
        checkOutput("basic_idle",      64'(bus.tile_valid_o), 64'(0));

        // Backpressure: three stalled cycles at beat 5
        applyStimulus(1);
        begin
            int n = 0;
            while (!(bus.tile_valid_o && bus.tile_idx_o == 5) && n < 100) begin
                @(posedge clk); #1; n++;
            end
            bus.tile_ready_i = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                checkOutput("stall_idx", 64'(bus.tile_idx_o), 64'(5));
            end
            bus.tile_ready_i = 1'b1;
        end
        wait_group_done();
        checkOutput("bp_beats",       64'(beats),        64'(32));
        checkOutput("bp_valid_cyc",   64'(valid_cycles), 64'(35));
        checkOutput("bp_outst",       64'(bus.outst_o),  64'(2));

        // Drain, then underflow
        pulse_yfinal();
        pulse_yfinal();
        checkOutput("drain_outst",     64'(bus.outst_o),     64'(0));
        checkOutput("drain_underflow", 64'(bus.underflow_o), 64'(0));
        pulse_yfinal();
        checkOutput("uf_flag",  64'(bus.underflow_o), 64'(1));
        checkOutput("uf_outst", 64'(bus.outst_o),     64'(0));

`ifdef SSM_STREAMER_CREDIT_EN
        for (int g = 2; g < 6; g++) begin
            applyStimulus(g);
            wait_group_done();
        end
        checkOutput("credit_outst_full", 64'(bus.outst_o), 64'(4));
        build_group(6);
        bus.grp_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("credit_block", 64'(bus.grp_ready_o), 64'(0));
        end
        @(posedge clk); #1;
        bus.y_final_valid_i = 1'b1;
        @(negedge clk);
        checkOutput("credit_release", 64'(bus.grp_ready_o), 64'(1));
        @(posedge clk); #1;
        bus.y_final_valid_i = 1'b0;
        bus.grp_valid_i     = 1'b0;
        checkOutput("credit_outst_kept", 64'(bus.outst_o),      64'(4));
        checkOutput("credit_accepted",   64'(bus.tile_valid_o), 64'(1));
        wait_group_done();
`else
        for (int g = 2; g < 8; g++) begin
            applyStimulus(g);
            wait_group_done();
            if (g == 5) checkOutput("sat_outst_4", 64'(bus.outst_o), 64'(4));
        end
        checkOutput("sat_outst_6", 64'(bus.outst_o), 64'(4));
`endif

        // Mid-group reset at beat 10
        applyStimulus(9);
        begin
            int n = 0;
            while (!(bus.tile_valid_o && bus.tile_idx_o == 10) && n < 100) begin
                @(posedge clk); #1; n++;
            end
        end
        rstn = 1'b0;
        #1;
        checkOutput("mrst_tile_valid", 64'(bus.tile_valid_o), 64'(0));
        checkOutput("mrst_outst",      64'(bus.outst_o),      64'(0));
        checkOutput("mrst_underflow",  64'(bus.underflow_o),  64'(0));
        checkOutput("mrst_busy",       64'(bus.busy_o),       64'(0));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        valid_cycles = 0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("mrst_no_beats", 64'(valid_cycles), 64'(0));
        applyStimulus(10);
        checkOutput("mrst_next_idx",   64'(bus.tile_idx_o),   64'(0));
        checkOutput("mrst_next_valid", 64'(bus.tile_valid_o), 64'(1));
        wait_group_done();
        checkOutput("mrst_next_beats", 64'(beats), 64'(32));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
